shot_sequencer: RTL and testbench
=================================

Name: shot_sequencer

Overview:
- Game-level controller for the 10x10 battleship grid array.
- Accepts one fire request at a time and drives the grid's per-cell shot, is_ship and ship_sunk vectors.
- Tracks per-ship hit counts. When a ship sinks, scans the board to mark the ship and its 8-neighbour halo as sunk.
- Reports each shot result and a sticky game-over flag to the top-level game FSM.

Parameters:
- LEN1, 5, length of ship id 1
- LEN2, 4, length of ship id 2
- LEN3, 3, length of ship id 3
- LEN4, 3, length of ship id 4
- LEN5, 2, length of ship id 5

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- fire_valid  in  1  fire request
- fire_row  in  4  target row, 0-9
- fire_col  in  4  target column, 0-9
- fire_ready  out  1  sequencer can accept a request
- ship_map  in  300  3-bit ship id per cell at [idx*3 +: 3], idx = row*10+col; 0 = water, 1-5 = ship; held stable outside reset
- cell_state_flat  in  400  one-hot cell states from the grid (BLUE=0001, GRAY=0010, BLACK=0100, RED=1000)
- shot  out  100  one-cycle shot strobe per cell
- is_ship  out  100  is_ship[i] = (ship_map id of cell i != 0), combinational
- ship_sunk  out  100  one-cycle sunk strobe per cell
- result_valid  out  1  one-cycle result pulse
- result_code  out  2  0=MISS, 1=HIT, 2=SUNK, 3=INVALID
- result_ship  out  3  ship id for HIT/SUNK, else 0
- game_over  out  1  sticky; all five ships sunk
- shots_fired  out  7  count of accepted valid shots, saturates at 100

Behaviour:
- Reset (reset==0 at a clk edge) forces IDLE and clears all registered state.
  - fire_ready=0 during reset, 1 in the first IDLE cycle after.
  - shot=0, ship_sunk=0, result_valid=0, result_code=0, result_ship=0, game_over=0, shots_fired=0.
  - All hit counters and the scan index clear.
  - Reset mid-operation, including mid-MARK, aborts immediately with no partial strobes afterwards.
- States: IDLE, CHECK, FIRE, UPDATE, MARK.
- IDLE:
  - fire_ready = 1 & !game_over.
  - On fire_valid & fire_ready: latch row/col, go CHECK (cycle T).
  - fire_valid with fire_ready=0 is ignored, not queued.
- CHECK (T+1): compute idx = row*10+col.
  - If row>9, col>9, or cell idx state != BLUE: result_valid=1, code=INVALID, ship=0 registered for cycle T+2; go IDLE.
  - Otherwise go FIRE.
- FIRE (T+2):
  - shot[idx]=1 for exactly this one cycle; all other shot bits 0.
  - shots_fired increments, saturating at 100.
- UPDATE (T+3):
  - id = ship_map[idx]. id==0: MISS, result in T+4, go IDLE.
  - id!=0: hit_cnt[id]+1.
    - New count < LEN(id): HIT, result_ship=id in T+4, go IDLE.
    - New count == LEN(id): mark ship id sunk and enter MARK with scan index 0.
- MARK: one cell per cycle, index 0..99.
  - ship_sunk[index]=1 for that cycle iff the cell's id == sunk id, or any in-bounds 8-neighbour has id == sunk id.
  - Out-of-board neighbours are ignored; row/col edges do not wrap.
  - After index 99: SUNK, result_ship=id in the next cycle.
  - If all five ships are now sunk, game_over=1 on that same cycle; go IDLE.
  - Sunk latency: result at T+3+101 = T+104.
- At most one of shot or ship_sunk is asserted per cycle; each is at most one-hot.
- Hit counters never exceed LEN; a sunk ship cannot be hit again because its cells are RED and fail CHECK.
- result_valid is 0 at all other times; result_code and result_ship hold their last value.
- game_over clears only on reset. While set, fire_ready=0 and the sequencer stays IDLE.

Test Plan:
- Empty ship_map, fire (3,4) at T → shot[34]=1 only at T+2; result MISS at T+4; shots_fired=1; fire_ready back to 1 at T+4.
- Ship 5 at cells 0 and 1, fire (0,0) → HIT, result_ship=5 at T+4. Fire (0,0) again → INVALID at T+2, no shot pulse, shots_fired unchanged.
- Then fire (0,1) → MARK strobes ship_sunk exactly on idx {0,1,2,10,11,12}, each once. SUNK, ship 5 at T+104.
- fire_row=10 → INVALID; fire_valid held during CHECK/FIRE/MARK → ignored, fire_ready=0 throughout.
- Sink all five ships (lengths 5,4,3,3,2) → game_over rises with the final SUNK pulse; later fire_valid ignored; shots_fired=17 with no misses.
- Reset low during MARK at index 40 → next cycle all strobes 0, hit counters 0, game_over 0; subsequent fire accepted normally.

Source files
------------

// File: rtl/shot_sequencer.sv
// rtl/shot_sequencer.sv - fire-request sequencer for the 10x10 battleship grid
module shot_sequencer #(
  parameter int LEN1 = 5,
  parameter int LEN2 = 4,
  parameter int LEN3 = 3,
  parameter int LEN4 = 3,
  parameter int LEN5 = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fire_valid,
  input  logic [3:0]   fire_row,
  input  logic [3:0]   fire_col,
  output logic         fire_ready,
  input  logic [299:0] ship_map,
  input  logic [399:0] cell_state_flat,
  output logic [99:0]  shot,
  output logic [99:0]  is_ship,
  output logic [99:0]  ship_sunk,
  output logic         result_valid,
  output logic [1:0]   result_code,
  output logic [2:0]   result_ship,
  output logic         game_over,
  output logic [6:0]   shots_fired
);

  typedef enum logic [2:0] {IDLE, CHECK, FIRE, UPDATE, MARK} state_t;

  localparam logic [1:0] RES_MISS    = 2'd0;
  localparam logic [1:0] RES_HIT     = 2'd1;
  localparam logic [1:0] RES_SUNK    = 2'd2;
  localparam logic [1:0] RES_INVALID = 2'd3;

  state_t      state, state_nxt;
  logic [3:0]  row_q, col_q;
  logic [3:0]  scan_row, scan_col;
  logic [2:0]  cur_id;
  logic [2:0]  hit_cnt [1:5];
  logic [4:0]  sunk_q;

  logic        on_board, cell_ok, is_hit, sinks, mark_hit, scan_last;
  logic [6:0]  idx7, scan_idx;
  logic [2:0]  cell_id, cell_len, cur_cnt, new_cnt;

  function automatic logic [2:0] len_of(input logic [2:0] id);
    case (id)
      3'd1:    len_of = 3'(LEN1);
      3'd2:    len_of = 3'(LEN2);
      3'd3:    len_of = 3'(LEN3);
      3'd4:    len_of = 3'(LEN4);
      3'd5:    len_of = 3'(LEN5);
      default: len_of = 3'd0;
    endcase
  endfunction

  for (genvar i = 0; i < 100; i++) begin : g_is_ship
    assign is_ship[i] = |ship_map[i*3 +: 3];
  end

  // Off-board coordinates are clamped to cell 0 so lookups stay in range.
  assign on_board  = (row_q <= 4'd9) && (col_q <= 4'd9);
  assign idx7      = on_board ? (7'(row_q) * 7'd10 + 7'(col_q)) : 7'd0;
  assign cell_ok   = on_board && (cell_state_flat[{idx7, 2'b00} +: 4] == 4'b0001);
  assign cell_id   = ship_map[9'(idx7) * 9'd3 +: 3];
  assign is_hit    = (cell_id >= 3'd1) && (cell_id <= 3'd5);
  assign cell_len  = len_of(cell_id);
  assign cur_cnt   = is_hit ? hit_cnt[cell_id] : 3'd0;
  assign new_cnt   = cur_cnt + 3'd1;
  assign sinks     = is_hit && (new_cnt == cell_len);
  assign scan_idx  = 7'(scan_row) * 7'd10 + 7'(scan_col);
  assign scan_last = (scan_row == 4'd9) && (scan_col == 4'd9);

  // Scanned cell belongs to the sunk ship or touches it in any of 8 directions.
  always_comb begin
    mark_hit = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((int'(scan_row) + dr >= 0) && (int'(scan_row) + dr <= 9) &&
            (int'(scan_col) + dc >= 0) && (int'(scan_col) + dc <= 9)) begin
          if (ship_map[((int'(scan_row) + dr) * 10 + int'(scan_col) + dc) * 3 +: 3] == cur_id)
            mark_hit = 1'b1;
        end
      end
    end
  end

  assign fire_ready = reset && (state == IDLE) && !game_over;
  assign shot       = (state == FIRE) ? (100'd1 << idx7) : 100'd0;
  assign ship_sunk  = (state == MARK && mark_hit) ? (100'd1 << scan_idx) : 100'd0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire_valid && fire_ready) state_nxt = CHECK;
      CHECK:   state_nxt = cell_ok ? FIRE : IDLE;
      FIRE:    state_nxt = UPDATE;
      UPDATE:  state_nxt = sinks ? MARK : IDLE;
      MARK:    if (scan_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      row_q        <= 4'd0;
      col_q        <= 4'd0;
      scan_row     <= 4'd0;
      scan_col     <= 4'd0;
      cur_id       <= 3'd0;
      sunk_q       <= 5'd0;
      result_valid <= 1'b0;
      result_code  <= RES_MISS;
      result_ship  <= 3'd0;
      game_over    <= 1'b0;
      shots_fired  <= 7'd0;
      for (int i = 1; i <= 5; i++) hit_cnt[i] <= 3'd0;
    end else begin
      state        <= state_nxt;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fire_valid && fire_ready) begin
            row_q <= fire_row;
            col_q <= fire_col;
          end
        end
        CHECK: begin
          if (!cell_ok) begin
            result_valid <= 1'b1;
            result_code  <= RES_INVALID;
            result_ship  <= 3'd0;
          end
        end
        FIRE: begin
          if (shots_fired != 7'd100) shots_fired <= shots_fired + 7'd1;
        end
        UPDATE: begin
          if (!is_hit) begin
            result_valid <= 1'b1;
            result_code  <= RES_MISS;
            result_ship  <= 3'd0;
          end else begin
            hit_cnt[cell_id] <= new_cnt;
            if (!sinks) begin
              result_valid <= 1'b1;
              result_code  <= RES_HIT;
              result_ship  <= cell_id;
            end else begin
              cur_id                <= cell_id;
              sunk_q[cell_id - 3'd1] <= 1'b1;
              scan_row              <= 4'd0;
              scan_col              <= 4'd0;
            end
          end
        end
        MARK: begin
          if (scan_last) begin
            result_valid <= 1'b1;
            result_code  <= RES_SUNK;
            result_ship  <= cur_id;
            game_over    <= &sunk_q;
            scan_row     <= 4'd0;
            scan_col     <= 4'd0;
          end else if (scan_col == 4'd9) begin
            scan_col <= 4'd0;
            scan_row <= scan_row + 4'd1;
          end else begin
            scan_col <= scan_col + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_sequencer.sv
// tb/tb_shot_sequencer.sv - scoreboard bench for shot_sequencer
module tb_shot_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         fire_valid;
  logic [3:0]   fire_row, fire_col;
  logic         fire_ready;
  logic [299:0] ship_map;
  logic [399:0] cell_state_flat;
  logic [99:0]  shot, is_ship, ship_sunk;
  logic         result_valid;
  logic [1:0]   result_code;
  logic [2:0]   result_ship;
  logic         game_over;
  logic [6:0]   shots_fired;

  always #5 clk = ~clk;

  shot_sequencer dut (
    .clk(clk), .reset(reset), .fire_valid(fire_valid), .fire_row(fire_row),
    .fire_col(fire_col), .fire_ready(fire_ready), .ship_map(ship_map),
    .cell_state_flat(cell_state_flat), .shot(shot), .is_ship(is_ship),
    .ship_sunk(ship_sunk), .result_valid(result_valid), .result_code(result_code),
    .result_ship(result_ship), .game_over(game_over), .shots_fired(shots_fired)
  );

  typedef struct {int code; int ship; int cyc; int go;} res_t;
  typedef struct {int idx; int cyc;} shot_t;
  res_t  rq[$];
  shot_t sq[$];
  int    total = 0, bad = 0, cyc = 0;
  int    sunk_cnt[100];
  logic [3:0] cs [100];

  always @(posedge clk) cyc++;

  // Grid model: a fired cell turns RED on a ship, GRAY on water.
  always @(posedge clk) begin
    for (int i = 0; i < 100; i++) begin
      if (!reset) cs[i] <= 4'b0001;
      else if (shot[i]) cs[i] <= is_ship[i] ? 4'b1000 : 4'b0010;
    end
  end
  always_comb for (int i = 0; i < 100; i++) cell_state_flat[i*4 +: 4] = cs[i];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic int first_set(input logic [99:0] v);
    for (int i = 0; i < 100; i++) if (v[i]) return i;
    return -1;
  endfunction

  res_t  er;
  shot_t es;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (result_valid) begin
        if (rq.size() == 0) fail("unexpected_result");
        else begin
          er = rq.pop_front();
          chk("result_code", result_code, er.code);
          chk("result_ship", result_ship, er.ship);
          chk("result_cycle", cyc, er.cyc);
          chk("game_over_at_result", game_over, er.go);
        end
      end
      if (shot != 100'd0) begin
        chk("shot_bits", $countones(shot), 1);
        if (sq.size() == 0) fail("unexpected_shot");
        else begin
          es = sq.pop_front();
          chk("shot_idx", first_set(shot), es.idx);
          chk("shot_cycle", cyc, es.cyc);
        end
      end
      if (ship_sunk != 100'd0) begin
        chk("sunk_bits", $countones(ship_sunk), 1);
        chk("sunk_with_shot", $countones(shot), 0);
        sunk_cnt[first_set(ship_sunk)]++;
      end
    end
  end

  task automatic set_fleet(input logic full);
    logic [299:0] m;
    m = '0;
    if (full) begin
      for (int c = 0; c < 5; c++) m[(20 + c)*3 +: 3] = 3'd1;
      for (int c = 0; c < 4; c++) m[(40 + c)*3 +: 3] = 3'd2;
      for (int c = 0; c < 3; c++) m[(60 + c)*3 +: 3] = 3'd3;
      for (int c = 0; c < 3; c++) m[(80 + c)*3 +: 3] = 3'd4;
      m[0 +: 3] = 3'd5;
      m[3 +: 3] = 3'd5;
    end
    ship_map = m;
  endtask

  task automatic do_reset(input logic full);
    @(negedge clk);
    reset = 1'b0;
    fire_valid = 1'b0;
    rq.delete();
    sq.delete();
    set_fleet(full);
    for (int i = 0; i < 100; i++) sunk_cnt[i] = 0;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", fire_ready, 0);
    chk("shot_in_reset", $countones(shot), 0);
    chk("sunk_in_reset", $countones(ship_sunk), 0);
    chk("rv_in_reset", result_valid, 0);
    chk("code_in_reset", result_code, 0);
    chk("rship_in_reset", result_ship, 0);
    chk("go_in_reset", game_over, 0);
    chk("shots_in_reset", shots_fired, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", fire_ready, 1);
  endtask

  task automatic fire(input int r, input int c, input int code, input int ship,
                      input int lat, input int go, input int exp_rdy, input int hold);
    int t, w;
    logic leak;
    w = 0;
    while (!fire_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!fire_ready) begin
      fail("ready_timeout");
      return;
    end
    t = cyc;
    rq.push_back('{code, ship, t + lat, go});
    if (code != 3) sq.push_back('{r*10 + c, t + 2});
    fire_valid = 1'b1;
    fire_row = 4'(r);
    fire_col = 4'(c);
    @(negedge clk);
    leak = 1'b0;
    fire_valid = hold[0];
    fire_row = 4'd5;
    fire_col = 4'd5;
    while (cyc < t + lat) begin
      if (fire_ready) leak = 1'b1;
      @(negedge clk);
    end
    fire_valid = 1'b0;
    chk("busy_ready_low", leak, 0);
    chk("ready_after_result", fire_ready, exp_rdy);
  endtask

  initial begin
    int t;
    logic leak;
    reset = 1'b0;
    fire_valid = 1'b0;
    fire_row = 4'd0;
    fire_col = 4'd0;
    ship_map = '0;

    do_reset(1'b0);
    fire(3, 4, 0, 0, 4, 0, 1, 0);
    chk("shots_after_miss", shots_fired, 1);

    do_reset(1'b1);
    fire(0, 0, 1, 5, 4, 0, 1, 0);
    fire(0, 0, 3, 0, 2, 0, 1, 0);
    chk("shots_after_invalid", shots_fired, 1);
    fire(10, 0, 3, 0, 2, 0, 1, 1);
    fire(0, 1, 2, 5, 104, 0, 1, 1);
    for (int i = 0; i < 100; i++)
      chk($sformatf("sunk_cnt_%0d", i), sunk_cnt[i],
          (i inside {0, 1, 2, 10, 11, 12}) ? 1 : 0);
    for (int c = 0; c < 4; c++) fire(2, c, 1, 1, 4, 0, 1, 0);
    fire(2, 4, 2, 1, 104, 0, 1, 0);
    for (int c = 0; c < 3; c++) fire(4, c, 1, 2, 4, 0, 1, 0);
    fire(4, 3, 2, 2, 104, 0, 1, 0);
    for (int c = 0; c < 2; c++) fire(6, c, 1, 3, 4, 0, 1, 0);
    fire(6, 2, 2, 3, 104, 0, 1, 0);
    for (int c = 0; c < 2; c++) fire(8, c, 1, 4, 4, 0, 1, 0);
    fire(8, 2, 2, 4, 104, 1, 0, 0);
    chk("shots_all_sunk", shots_fired, 17);
    fire_valid = 1'b1;
    fire_row = 4'd5;
    fire_col = 4'd5;
    leak = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (fire_ready) leak = 1'b1;
    end
    fire_valid = 1'b0;
    chk("ready_after_game_over", leak, 0);
    chk("game_over_sticky", game_over, 1);
    chk("shots_after_game_over", shots_fired, 17);

    do_reset(1'b1);
    fire(0, 0, 1, 5, 4, 0, 1, 0);
    t = cyc;
    sq.push_back('{1, t + 2});
    fire_valid = 1'b1;
    fire_row = 4'd0;
    fire_col = 4'd1;
    @(negedge clk);
    fire_valid = 1'b0;
    while (cyc < t + 44) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_shot", $countones(shot), 0);
    chk("abort_sunk", $countones(ship_sunk), 0);
    chk("abort_rv", result_valid, 0);
    chk("abort_go", game_over, 0);
    chk("abort_shots", shots_fired, 0);
    chk("abort_ready", fire_ready, 0);
    chk("abort_sunk_partial", sunk_cnt[1] + sunk_cnt[10], 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fire(0, 0, 1, 5, 4, 0, 1, 0);
    chk("shots_after_abort", shots_fired, 1);

    repeat (5) @(negedge clk);
    chk("results_pending", rq.size(), 0);
    chk("shots_pending", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

endmodule
